// File: rtl/adc_capture_pkg.sv
// Shared types for the oscilloscope capture sequencer: FSM state encoding,
// the datapath config bundle and a small state classification helper.
package adc_capture_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } capture_state_e;

  typedef struct packed {
    logic       couple;
    logic [3:0] scale;
    logic [9:0] offset;
  } cfg_t;

  function automatic logic is_busy(input capture_state_e s);
    return (s == PRE) || (s == WAIT_TRIG) || (s == POST);
  endfunction

endpackage

// File: rtl/adc_trig_detect.sv
// Level/edge trigger detector on the scaled sample stream. Keeps the previous
// sample and a pending force request; hit is combinational with sample_valid.
module adc_trig_detect #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              track,
  input  logic              eval,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_falling,
  input  logic              force_trig,
  output logic              hit
);

  logic signed [DATA_W-1:0] prev_q;
  logic signed [DATA_W-1:0] samp;
  logic signed [DATA_W-1:0] lvl;
  logic                     prev_vld_q;
  logic                     force_pend_q;
  logic                     edge_hit;

  assign samp = sample_data;
  assign lvl  = trig_level;

  // A crossing needs a valid previous sample from the current frame.
  always_comb begin
    edge_hit = 1'b0;
    if (prev_vld_q) begin
      if (trig_falling) edge_hit = (prev_q > lvl) && (samp <= lvl);
      else              edge_hit = (prev_q < lvl) && (samp >= lvl);
    end
  end

  assign hit = eval && sample_valid && (edge_hit || force_trig || force_pend_q);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
      force_pend_q <= 1'b0;
    end else begin
      if (track && sample_valid) begin
        prev_q     <= samp;
        prev_vld_q <= 1'b1;
      end
      // A force without a sample waits for the next valid sample.
      if (hit)                    force_pend_q <= 1'b0;
      else if (eval && force_trig) force_pend_q <= 1'b1;
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Trigger/capture sequencer for one scope channel: shadows datapath config per
// frame and writes a circular pre/post-trigger frame into the sample buffer.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic              cfg_couple,
  input  logic [3:0]        cfg_scale,
  input  logic [9:0]        cfg_offset,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_falling,
  input  logic [ADDR_W-1:0] pretrig_len,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              couple_out,
  output logic [3:0]        scale_out,
  output logic [9:0]        offset_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state
);

  capture_state_e    state_q;
  cfg_t              cfg_q;
  cfg_t              cfg_in;
  logic [ADDR_W-1:0] pre_q;
  logic [ADDR_W-1:0] pre_eff;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [ADDR_W-1:0] trig_addr_q;
  logic [ADDR_W-1:0] start_addr_q;
  logic              busy_q;
  logic              done_q;
  logic              accept;
  logic              arm_ok;
  logic              trig_hit;

  assign cfg_in  = {cfg_couple, cfg_scale, cfg_offset};
  // pretrig_len is ADDR_W wide, so it can never exceed DEPTH-1.
  assign pre_eff = pretrig_len;
  // Samples arriving with abort are dropped; only the already registered write lands.
  assign accept  = is_busy(state_q) && sample_valid && !abort;
  assign arm_ok  = arm && !abort && ((state_q == IDLE) || (state_q == DONE));

  adc_trig_detect #(.DATA_W(DATA_W)) u_trig (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (arm_ok),
    .track        (accept),
    .eval         (state_q == WAIT_TRIG && !abort),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .force_trig   (force_trig),
    .hit          (trig_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cfg_q        <= '0;
      pre_q        <= '0;
      cnt_q        <= '0;
      ptr_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        wr_addr_q <= ptr_q;
        wr_data_q <= sample_data;
        ptr_q     <= ptr_q + 1'b1;
      end
      if (abort && busy_q) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (arm_ok) begin
              cfg_q   <= cfg_in;
              pre_q   <= pre_eff;
              cnt_q   <= pre_eff;
              ptr_q   <= '0;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              state_q <= (pre_eff != '0) ? PRE : WAIT_TRIG;
            end
          end
          PRE: begin
            if (accept) begin
              cnt_q <= cnt_q - 1'b1;
              if (cnt_q == ADDR_W'(1)) state_q <= WAIT_TRIG;
            end
          end
          WAIT_TRIG: begin
            if (accept && trig_hit) begin
              trig_addr_q  <= ptr_q;
              start_addr_q <= ptr_q - pre_q;
              // Remaining post samples: DEPTH-1-pre_eff.
              cnt_q        <= ~pre_q;
              if (pre_q == '1) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= POST;
              end
            end
          end
          POST: begin
            if (accept) begin
              cnt_q <= cnt_q - 1'b1;
              if (cnt_q == ADDR_W'(1)) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign couple_out = cfg_q.couple;
  assign scale_out  = cfg_q.scale;
  assign offset_out = cfg_q.offset;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign state      = state_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl with a 16-entry buffer: trigger-compare vector
// table, hand-written frame sequences and a write scoreboard.
module tb_adc_capture_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic              force_trig = 1'b0;
  logic              cfg_couple = 1'b0;
  logic [3:0]        cfg_scale = '0;
  logic [9:0]        cfg_offset = '0;
  logic [DATA_W-1:0] trig_level = '0;
  logic              trig_falling = 1'b0;
  logic [ADDR_W-1:0] pretrig_len = '0;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] sample_data = '0;
  logic              couple_out;
  logic [3:0]        scale_out;
  logic [9:0]        offset_out;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;
  logic              busy;
  logic              done;
  logic [2:0]        state;

  int total = 0;
  int bad = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W+DATA_W-1:0] mon_e;
  logic [ADDR_W-1:0]        exp_ptr = '0;

  typedef struct {
    logic signed [31:0] lvl;
    logic               fall;
    logic signed [31:0] s0;
    logic signed [31:0] s1;
    logic signed [31:0] s2;
    int                 hit_idx;
  } vec_t;
  vec_t vecs[8];

  adc_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .force_trig(force_trig),
    .cfg_couple(cfg_couple), .cfg_scale(cfg_scale), .cfg_offset(cfg_offset),
    .trig_level(trig_level), .trig_falling(trig_falling), .pretrig_len(pretrig_len),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .couple_out(couple_out), .scale_out(scale_out), .offset_out(offset_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .trig_addr(trig_addr), .start_addr(start_addr),
    .busy(busy), .done(done), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, want end of test");
    $fatal(1, "watchdog");
  end

  // scoreboard: every buffer write must match the oldest expected {addr,data}
  always @(negedge clk) begin
    if (wr_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: addr=%0d data=%0d, want no write", wr_addr, $signed(wr_data));
      end else begin
        mon_e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== mon_e) begin
          bad++;
          $display("FAIL wr_match: addr=%0d data=%0d, want addr=%0d data=%0d",
                   wr_addr, $signed(wr_data), mon_e[ADDR_W+DATA_W-1:DATA_W],
                   $signed(mon_e[DATA_W-1:0]));
        end
      end
    end
  end

  // driver tasks
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    sample_valid = 1'b0;
    tick();
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input bit exp_wr);
    sample_valid = 1'b1;
    sample_data  = d;
    if (exp_wr) begin
      exp_q.push_back({exp_ptr, d});
      exp_ptr++;
    end
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [ADDR_W-1:0] pre);
    pretrig_len = pre;
    arm = 1'b1;
    exp_ptr = '0;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    vecs[0] = '{lvl: 100, fall: 1'b0, s0: 90,  s1: 100, s2: 120, hit_idx: 1};
    vecs[1] = '{lvl: 100, fall: 1'b0, s0: 100, s1: 120, s2: 130, hit_idx: -1};
    vecs[2] = '{lvl: 0,   fall: 1'b1, s0: 1,   s1: 0,   s2: -2,  hit_idx: 1};
    vecs[3] = '{lvl: -5,  fall: 1'b0, s0: -10, s1: 3,   s2: 4,   hit_idx: 1};
    vecs[4] = '{lvl: -5,  fall: 1'b1, s0: 0,   s1: -4,  s2: -6,  hit_idx: 2};
    vecs[5] = '{lvl: 0,   fall: 1'b1, s0: 0,   s1: 0,   s2: -1,  hit_idx: -1};
    vecs[6] = '{lvl: 50,  fall: 1'b0, s0: 200, s1: 10,  s2: 60,  hit_idx: 2};
    vecs[7] = '{lvl: 20,  fall: 1'b1, s0: 0,   s1: 0,   s2: 0,   hit_idx: -1};

    // reset state
    cfg_scale = 4'd9;
    cfg_couple = 1'b1;
    tick(); tick();
    chk("rst_state", state, S_IDLE);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_wr", {wr_en, wr_addr, wr_data}, '0);
    chk("rst_addrs", {trig_addr, start_addr}, '0);
    chk("rst_cfg", {couple_out, scale_out, offset_out}, '0);
    rst_n = 1'b1;
    tick();

    // trigger compare table, pretrig 0, every row aborted afterwards
    for (int i = 0; i < 8; i++) begin
      trig_level   = vecs[i].lvl;
      trig_falling = vecs[i].fall;
      do_arm('0);
      chk($sformatf("tbl%0d_arm", i), {busy, state}, {1'b1, S_WAIT});
      send(vecs[i].s0, 1'b1);
      send(vecs[i].s1, 1'b1);
      send(vecs[i].s2, 1'b1);
      chk($sformatf("tbl%0d_state", i), state, (vecs[i].hit_idx >= 0) ? S_POST : S_WAIT);
      if (vecs[i].hit_idx >= 0)
        chk($sformatf("tbl%0d_taddr", i), trig_addr, vecs[i].hit_idx);
      do_abort();
      chk($sformatf("tbl%0d_abort", i), {busy, done, state}, {2'b00, S_IDLE});
    end

    // rising ramp with 4 pre-trigger samples
    trig_level = 100;
    trig_falling = 1'b0;
    do_arm(4'd4);
    chk("ramp_pre", state, S_PRE);
    for (int i = 0; i < 4; i++) send(i * 10, 1'b1);
    chk("ramp_wait", state, S_WAIT);
    for (int i = 4; i <= 10; i++) send(i * 10, 1'b1);
    chk("ramp_post", state, S_POST);
    chk("ramp_taddr", trig_addr, 10);
    chk("ramp_saddr", start_addr, 6);
    for (int j = 0; j < 10; j++) send(110 + j * 10, 1'b1);
    chk("ramp_not_done", {done, state}, {1'b0, S_POST});
    send(210, 1'b1);
    chk("ramp_done", {done, busy, state}, {2'b10, S_DONE});
    send(999, 1'b0);
    chk("ramp_hold", {trig_addr, start_addr, wr_en}, {4'd10, 4'd6, 1'b0});

    // falling edge sequence 5,3,1,0,-2
    trig_level = 0;
    trig_falling = 1'b1;
    do_arm('0);
    send(5, 1'b1);
    chk("fall_first", state, S_WAIT);
    send(3, 1'b1);
    send(1, 1'b1);
    chk("fall_pre_hit", state, S_WAIT);
    send(0, 1'b1);
    chk("fall_hit", {state, trig_addr}, {S_POST, 4'd3});
    send(-2, 1'b1);
    do_abort();

    // config shadowing across a frame
    cfg_couple = 1'b1;
    cfg_scale = 4'd6;
    cfg_offset = 10'h155;
    trig_level = 1000;
    trig_falling = 1'b0;
    do_arm(4'd2);
    chk("cfg_latched", {couple_out, scale_out, offset_out}, {1'b1, 4'd6, 10'h155});
    cfg_couple = 1'b0;
    cfg_scale = 4'd3;
    cfg_offset = 10'h0;
    send(1, 1'b1);
    send(2, 1'b1);
    chk("cfg_mid", scale_out, 4'd6);
    force_trig = 1'b1;
    send(3, 1'b1);
    force_trig = 1'b0;
    chk("cfg_trig", {state, trig_addr}, {S_POST, 4'd2});
    for (int j = 0; j < 13; j++) send($urandom_range(0, 900), 1'b1);
    chk("cfg_done", {done, scale_out}, {1'b1, 4'd6});
    do_arm('0);
    chk("cfg_rearm", {couple_out, scale_out, offset_out}, {1'b0, 4'd3, 10'h0});

    // force with no sample, then arm while busy, then abort in POST
    force_trig = 1'b1;
    sample_valid = 1'b0;
    tick();
    force_trig = 1'b0;
    chk("force_nowr", {wr_en, state}, {1'b0, S_WAIT});
    idle_cycle();
    chk("force_pending", state, S_WAIT);
    send(7, 1'b1);
    chk("force_hit", {state, trig_addr}, {S_POST, 4'd0});
    pretrig_len = 4'd5;
    arm = 1'b1;
    send(8, 1'b1);
    arm = 1'b0;
    chk("arm_busy_ign", {state, trig_addr}, {S_POST, 4'd0});
    send(9, 1'b1);
    send(10, 1'b1);
    abort = 1'b1;
    send(11, 1'b0);
    abort = 1'b0;
    chk("abort_post", {busy, done, state, wr_en}, {2'b00, S_IDLE, 1'b0});
    chk("abort_cfg", scale_out, 4'd3);
    idle_cycle();
    chk("abort_quiet", wr_en, 1'b0);

    // maximum pretrigger: trigger goes straight to DONE
    do_arm(4'd15);
    chk("clamp_pre", state, S_PRE);
    for (int i = 0; i < 15; i++) send(500 + i, 1'b1);
    chk("clamp_wait", state, S_WAIT);
    force_trig = 1'b1;
    send(77, 1'b1);
    force_trig = 1'b0;
    chk("clamp_done", {done, busy, state, wr_en}, {2'b10, S_DONE, 1'b1});
    chk("clamp_addrs", {trig_addr, start_addr}, {4'd15, 4'd0});

    // reset in WAIT_TRIG
    do_arm('0);
    send(1, 1'b1);
    chk("rst_mid_pre", state, S_WAIT);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_state", {busy, done, state, wr_en}, '0);
    chk("rst_mid_addrs", {trig_addr, start_addr, wr_addr, wr_data}, '0);
    chk("rst_mid_cfg", {couple_out, scale_out, offset_out}, '0);
    rst_n = 1'b1;
    tick(); tick();

    chk("sb_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
